// File: rtl/pc_sequencer.sv
// Program-counter sequencer: holds the fetch PC, supplies both operands to the
// two-input select stage, and inserts redirect bubbles after taken branches.
module pc_sequencer #(
    parameter logic [31:0] RESET_PC         = 32'h0000_0000,
    parameter int unsigned REDIRECT_BUBBLES = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        fetch_ready,
    input  logic        branch_taken,
    input  logic [31:0] branch_target,
    output logic [31:0] pc,
    output logic        pc_valid,
    output logic [31:0] pc_plus4,
    output logic [31:0] target_aligned,
    output logic        sel,
    output logic [31:0] next_pc,
    output logic [15:0] branch_count
);

    localparam int unsigned PC_W  = 32;
    localparam int unsigned CNT_W = 16;
    localparam logic [1:0]  BUB_RELOAD = 2'(REDIRECT_BUBBLES);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    typedef enum logic [1:0] {
        S_INIT   = 2'd0,
        S_RUN    = 2'd1,
        S_BUBBLE = 2'd2
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;
    logic [1:0]        r_bub_cnt;
    logic [1:0]        w_bub_cnt_nxt;
    logic [PC_W-1:0]   r_pc;
    logic [PC_W-1:0]   w_pc_nxt;
    logic [CNT_W-1:0]  r_branch_count;
    logic [CNT_W-1:0]  w_branch_count_nxt;
    logic              r_pc_valid;
    logic              w_count_inc;
    logic              w_sel;
    logic [PC_W-1:0]   w_pc_plus4;
    logic [PC_W-1:0]   w_target_aligned;

    // State register; pc_valid is registered from the next-state decode.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state        <= S_INIT;
            r_bub_cnt      <= 2'd0;
            r_pc           <= RESET_PC;
            r_branch_count <= '0;
            r_pc_valid     <= 1'b0;
        end else begin
            r_state        <= w_state_nxt;
            r_bub_cnt      <= w_bub_cnt_nxt;
            r_pc           <= w_pc_nxt;
            r_branch_count <= w_branch_count_nxt;
            r_pc_valid     <= (w_state_nxt == S_RUN);
        end
    end

    // Next-state, next-pc and redirect counting.
    always_comb begin
        w_state_nxt   = r_state;
        w_bub_cnt_nxt = r_bub_cnt;
        w_pc_nxt      = r_pc;
        w_count_inc   = 1'b0;
        case (r_state)
            S_INIT: begin
                w_state_nxt = S_RUN;
            end
            S_RUN: begin
                if (branch_taken) begin
                    w_pc_nxt    = w_target_aligned;
                    w_count_inc = 1'b1;
                    if (BUB_RELOAD != 2'd0) begin
                        w_state_nxt   = S_BUBBLE;
                        w_bub_cnt_nxt = BUB_RELOAD;
                    end
                end else if (fetch_ready) begin
                    w_pc_nxt = w_pc_plus4;
                end
            end
            S_BUBBLE: begin
                if (branch_taken) begin
                    w_pc_nxt      = w_target_aligned;
                    w_count_inc   = 1'b1;
                    w_bub_cnt_nxt = BUB_RELOAD;
                end else if (r_bub_cnt == 2'd1) begin
                    w_state_nxt   = S_RUN;
                    w_bub_cnt_nxt = 2'd0;
                end else begin
                    w_bub_cnt_nxt = r_bub_cnt - 2'd1;
                end
            end
            default: begin
                w_state_nxt   = S_INIT;
                w_bub_cnt_nxt = 2'd0;
            end
        endcase
        w_branch_count_nxt = (w_count_inc && (r_branch_count != CNT_MAX))
                           ? r_branch_count + CNT_W'(1) : r_branch_count;
    end

    // Same-cycle mux operands and select.
    always_comb begin
        w_pc_plus4       = r_pc + PC_W'(4);
        w_target_aligned = branch_target & ~PC_W'(3);
        w_sel            = branch_taken & (r_state != S_INIT);
    end

    assign pc             = r_pc;
    assign pc_valid       = r_pc_valid;
    assign pc_plus4       = w_pc_plus4;
    assign target_aligned = w_target_aligned;
    assign sel            = w_sel;
    assign next_pc        = w_sel ? w_target_aligned : w_pc_plus4;
    assign branch_count   = r_branch_count;

endmodule

// File: tb/tb_pc_sequencer.sv
// Scoreboard bench for pc_sequencer: a cycle-level reference model queues the
// expected outputs for each cycle and a negedge monitor compares them.
module tb_pc_sequencer;

    localparam logic [31:0] RST_PC = 32'hFFFF_FFF0;
    localparam int          BUBS   = 2;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        fetch_ready = 1'b0;
    logic        branch_taken = 1'b0;
    logic [31:0] branch_target = 32'h0;
    logic [31:0] pc, pc_plus4, target_aligned, next_pc;
    logic        pc_valid, sel;
    logic [15:0] branch_count;

    pc_sequencer #(.RESET_PC(RST_PC), .REDIRECT_BUBBLES(BUBS)) dut (
        .clk(clk), .reset(reset), .fetch_ready(fetch_ready),
        .branch_taken(branch_taken), .branch_target(branch_target),
        .pc(pc), .pc_valid(pc_valid), .pc_plus4(pc_plus4),
        .target_aligned(target_aligned), .sel(sel), .next_pc(next_pc),
        .branch_count(branch_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] pc, pc_plus4, tgt, next_pc;
        logic        valid, sel;
        logic [15:0] cnt;
    } exp_t;

    exp_t q[$];
    int   errors = 0;
    int   checks = 0;

    // Reference model: init flag, remaining invalid cycles, saturating count.
    logic [31:0] m_pc = RST_PC;
    bit          m_init = 1'b1;
    int          m_bub = 0;
    int          m_cnt = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Advance the model across one rising edge using the inputs it sampled.
    task automatic model_edge();
        if (reset) begin
            m_pc = RST_PC; m_init = 1'b1; m_bub = 0; m_cnt = 0;
        end else if (m_init) begin
            m_init = 1'b0;
        end else if (branch_taken) begin
            m_pc  = {branch_target[31:2], 2'b00};
            m_cnt = (m_cnt < 65535) ? m_cnt + 1 : 65535;
            m_bub = BUBS;
        end else if (m_bub > 0) begin
            m_bub = m_bub - 1;
        end else if (fetch_ready) begin
            m_pc = m_pc + 32'd4;
        end
    endtask

    task automatic step(input bit rst, input bit fr, input bit br, input logic [31:0] tgt);
        exp_t e;
        @(posedge clk);
        #1;
        model_edge();
        reset = rst; fetch_ready = fr; branch_taken = br; branch_target = tgt;
        e.pc       = m_pc;
        e.valid    = !m_init && (m_bub == 0);
        e.sel      = br && !m_init;
        e.pc_plus4 = m_pc + 32'd4;
        e.tgt      = {tgt[31:2], 2'b00};
        e.next_pc  = e.sel ? e.tgt : e.pc_plus4;
        e.cnt      = 16'(m_cnt);
        q.push_back(e);
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (q.size() > 0) begin
            e = q.pop_front();
            check("pc", pc, e.pc);
            check("pc_valid", 32'(pc_valid), 32'(e.valid));
            check("sel", 32'(sel), 32'(e.sel));
            check("pc_plus4", pc_plus4, e.pc_plus4);
            check("target_aligned", target_aligned, e.tgt);
            check("next_pc", next_pc, e.next_pc);
            check("branch_count", 32'(branch_count), 32'(e.cnt));
        end
    end

    initial begin
        // Reset, then sequential advance across the 32-bit wrap.
        step(1, 0, 0, 0);
        step(1, 1, 1, 32'h1234);
        step(0, 1, 0, 0);
        #1;
        check("rst_pc", pc, RST_PC);
        check("rst_valid", 32'(pc_valid), 32'd0);
        check("rst_count", 32'(branch_count), 32'd0);
        check("init_sel", 32'(sel), 32'd0);
        repeat (5) step(0, 1, 0, 0);
        #1;
        check("wrap_pc", pc, 32'h0000_0000);
        check("wrap_valid", 32'(pc_valid), 32'd1);

        // Stall, then redirect and a second redirect mid-bubble.
        repeat (3) step(0, 0, 0, 0);
        step(0, 1, 1, 32'h0000_1003);
        #1;
        check("br_sel", 32'(sel), 32'd1);
        check("br_next_pc", next_pc, 32'h0000_1000);
        step(0, 1, 0, 0);
        #1;
        check("bub_pc", pc, 32'h0000_1000);
        check("bub_valid", 32'(pc_valid), 32'd0);
        check("bub_count", 32'(branch_count), 32'd1);
        step(0, 1, 1, 32'h0000_2000);
        step(0, 1, 0, 0);
        #1;
        check("rebr_pc", pc, 32'h0000_2000);
        check("rebr_valid", 32'(pc_valid), 32'd0);
        check("rebr_count", 32'(branch_count), 32'd2);
        step(0, 1, 0, 0);
        step(0, 1, 0, 0);
        #1;
        check("rebr_resume", 32'(pc_valid), 32'd1);

        // Reset concurrent with branch while bubbling.
        step(0, 1, 1, 32'h0000_4000);
        step(1, 1, 1, 32'h0000_8000);
        step(0, 1, 0, 0);
        #1;
        check("rstbr_pc", pc, RST_PC);
        check("rstbr_valid", 32'(pc_valid), 32'd0);
        check("rstbr_count", 32'(branch_count), 32'd0);

        // Randomized traffic with occasional reset.
        for (int i = 0; i < 3000; i++) begin
            step(($urandom % 64) == 0, ($urandom % 4) != 0,
                 ($urandom % 6) == 0, $urandom);
        end

        // Saturation of the redirect counter.
        step(1, 0, 0, 0);
        step(0, 0, 0, 0);
        for (int i = 0; i < 65540; i++) step(0, 1, 1, $urandom);
        step(0, 1, 0, 0);
        #1;
        check("sat_count", 32'(branch_count), 32'h0000_FFFF);

        for (int i = 0; i < 4 && q.size() > 0; i++) @(negedge clk);
        @(posedge clk);
        if (q.size() > 0) begin
            checks++;
            errors++;
            $display("FAIL drain: %0d entries left, expected 0", q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/pc_sequencer.md
# pc_sequencer

Program-counter sequencer for the fetch path, directly upstream of the 32-bit two-input select stage. It holds the current PC, presents PC+4 and the aligned branch target as the two operands, and drives the select that chooses between them. It inserts redirect bubbles after taken branches, handshakes PC delivery with fetch, and keeps a saturating count of taken redirects.

## Interface
- RESET_PC, 32'h0000_0000: PC value loaded on reset; bits [1:0] must be 0.
- REDIRECT_BUBBLES, 1: invalid cycles inserted after a taken branch; legal range 0-3.

- clk  in  1  single clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high; sampled on rising edge of clk.
- fetch_ready  in  1  fetch accepts pc this cycle.
- branch_taken  in  1  redirect request for this cycle.
- branch_target  in  32  redirect address; bits [1:0] ignored.
- pc  out  32  current fetch address (registered).
- pc_valid  out  1  pc is valid for fetch (registered state decode).
- pc_plus4  out  32  pc + 4, modulo 2^32 (combinational); drives mux input b.
- target_aligned  out  32  {branch_target[31:2], 2'b00} (combinational); drives mux input a.
- sel  out  1  mux select: 1 = target_aligned, 0 = pc_plus4 (combinational).
- next_pc  out  32  value pc loads on the next advancing edge (combinational, = sel ? target_aligned : pc_plus4).
- branch_count  out  16  taken redirects accepted since reset, saturating.

## Operation
- States: INIT, RUN, BUBBLE. 2-bit bubble counter bub_cnt.
- Reset: state=INIT, pc=RESET_PC, bub_cnt=0, branch_count=0. Outputs after reset edge: pc_valid=0, sel=0, pc_plus4=RESET_PC+4.
- INIT: pc_valid=0; branch_taken ignored, sel forced 0; unconditional transition to RUN next edge; pc held.
- RUN: pc_valid=1.
  - branch_taken=1 (priority over fetch_ready): pc <= target_aligned; branch_count += 1 (saturate at 16'hFFFF). If REDIRECT_BUBBLES=0 stay RUN; else go BUBBLE with bub_cnt <= REDIRECT_BUBBLES.
  - else fetch_ready=1: pc <= pc_plus4 (transfer complete).
  - else hold pc.
- BUBBLE: pc_valid=0; fetch_ready ignored.
  - branch_taken=1: pc <= target_aligned, branch_count += 1, bub_cnt reloaded to REDIRECT_BUBBLES, stay BUBBLE.
  - else bub_cnt == 1: go RUN; else bub_cnt -= 1. pc held.
- sel = branch_taken & (state != INIT).
- Wrap-around: pc=32'hFFFF_FFFC advancing yields 32'h0000_0000; no flag.
- reset asserted in any state, mid-bubble or concurrently with branch_taken: reset wins; all state returns to reset values on that edge.

## Timing
- Transfer occurs on an edge where pc_valid=1 and fetch_ready=1 and branch_taken=0.
- First valid pc: cycle 1 after reset deasserts (INIT lasts exactly one cycle).
- Branch latency: target appears on pc the edge after branch_taken sampled; pc_valid returns high exactly REDIRECT_BUBBLES cycles later.
- Sequential advance: one pc per cycle with fetch_ready held high.
- sel, next_pc, pc_plus4, target_aligned are same-cycle combinational; pc, pc_valid, branch_count change only on clk edges.

## Test plan
- Reset release, fetch_ready=1 for 4 cycles, RESET_PC=0 -> pc_valid 0 in cycle 0, then pc = 0x0, 0x4, 0x8 on consecutive valid cycles.
- fetch_ready low 3 cycles in RUN at pc=0x10 -> pc holds 0x10, pc_valid stays 1, sel=0, next_pc=0x14.
- branch_taken with target 0x0000_1003 at pc=0x8, REDIRECT_BUBBLES=1 -> sel=1 that cycle, pc=0x1000 next edge, pc_valid low 1 cycle, branch_count=1.
- Second branch_taken (target 0x2000) during BUBBLE, REDIRECT_BUBBLES=2 -> pc=0x2000, bubble counter reloads, pc_valid low 2 more cycles, branch_count=2.
- RESET_PC=32'hFFFF_FFF8, fetch_ready=1 -> pc sequence 0xFFFF_FFF8, 0xFFFF_FFFC, 0x0000_0000.
- reset asserted same cycle as branch_taken mid-BUBBLE -> pc=RESET_PC, pc_valid=0, branch_count=0 next edge; branch_count saturation: 65536 branches -> holds 16'hFFFF.
